// File: rtl/sigmoid_out_fifo.sv
// Result queue behind the sigmoid unit: DEPTH x 16-bit FIFO built from flip-flop cells,
// with a sticky drop flag and a transistor tally of every cell in the design.

module sigmoid_out_dff_cell (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        d,
    output logic        q,
    output logic [50:0] number
);
    // Enable-DFF with async clear: 24 transistors per bit.
    assign number = 51'd24;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  q <= 1'b0;
        else if (en) q <= d;
    end
endmodule

module sigmoid_out_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_in_valid,
    input  logic [15:0]              i_y,
    input  logic                     i_out_ready,
    input  logic                     i_clr_ovf,
    output logic [15:0]              o_y,
    output logic                     o_out_valid,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_overflow,
    output logic [50:0]              number
);
    localparam int AW      = $clog2(DEPTH);
    localparam int CW      = AW + 1;
    localparam int N_MEM   = DEPTH * 16;
    localparam int OFS_WP  = N_MEM;
    localparam int OFS_RP  = OFS_WP + AW;
    localparam int OFS_CNT = OFS_RP + AW;
    localparam int OFS_OVF = OFS_CNT + CW;
    localparam int N_CELLS = OFS_OVF + 1;

    logic [N_MEM-1:0] mem_q;
    logic [DEPTH-1:0] wr_en;
    logic [AW-1:0]    wptr_q, rptr_q, wptr_nxt, rptr_nxt;
    logic [CW-1:0]    count_q, count_nxt;
    logic             ovf_q, ovf_nxt;
    logic             push, pop, drop;
    logic [50:0]      num_cell [N_CELLS];

    assign o_out_valid = (count_q != '0);
    assign o_full      = (count_q == CW'(DEPTH));
    assign o_count     = count_q;
    assign o_overflow  = ovf_q;
    assign o_y         = o_out_valid ? mem_q[{rptr_q, 4'b0000} +: 16] : 16'h0000;

    // An empty queue never pops, so a push with ready asserted is a plain push.
    assign pop  = o_out_valid & i_out_ready;
    assign push = i_in_valid & (~o_full | pop);
    assign drop = i_in_valid & o_full & ~pop;

    always_comb begin
        wptr_nxt  = push ? wptr_q + AW'(1) : wptr_q;
        rptr_nxt  = pop  ? rptr_q + AW'(1) : rptr_q;
        count_nxt = count_q;
        if (push && !pop)      count_nxt = count_q + CW'(1);
        else if (pop && !push) count_nxt = count_q - CW'(1);
        ovf_nxt   = drop | (ovf_q & ~i_clr_ovf);
    end

    always_comb begin
        for (int e = 0; e < DEPTH; e++)
            wr_en[e] = push && (wptr_q == AW'(e));
    end

    for (genvar e = 0; e < DEPTH; e++) begin : g_entry
        for (genvar b = 0; b < 16; b++) begin : g_bit
            sigmoid_out_dff_cell u_cell (
                .clk(clk), .rst_n(rst_n), .en(wr_en[e]), .d(i_y[b]),
                .q(mem_q[e*16+b]), .number(num_cell[e*16+b])
            );
        end
    end

    for (genvar b = 0; b < AW; b++) begin : g_ptr
        sigmoid_out_dff_cell u_wp (
            .clk(clk), .rst_n(rst_n), .en(1'b1), .d(wptr_nxt[b]),
            .q(wptr_q[b]), .number(num_cell[OFS_WP+b])
        );
        sigmoid_out_dff_cell u_rp (
            .clk(clk), .rst_n(rst_n), .en(1'b1), .d(rptr_nxt[b]),
            .q(rptr_q[b]), .number(num_cell[OFS_RP+b])
        );
    end

    for (genvar b = 0; b < CW; b++) begin : g_cnt
        sigmoid_out_dff_cell u_cnt (
            .clk(clk), .rst_n(rst_n), .en(1'b1), .d(count_nxt[b]),
            .q(count_q[b]), .number(num_cell[OFS_CNT+b])
        );
    end

    sigmoid_out_dff_cell u_ovf (
        .clk(clk), .rst_n(rst_n), .en(1'b1), .d(ovf_nxt),
        .q(ovf_q), .number(num_cell[OFS_OVF])
    );

    always_comb begin
        number = '0;
        for (int i = 0; i < N_CELLS; i++)
            number = number + num_cell[i];
    end
endmodule

// File: tb/tb_sigmoid_out_fifo.sv
// Directed bench for sigmoid_out_fifo at DEPTH=4: ordering, full/overflow, wrap and reset.

module tb_sigmoid_out_fifo;
    localparam int DEPTH = 4;
    // 64 storage + 2+2 pointer + 3 count + 1 overflow cells, 24 transistors each
    localparam logic [50:0] EXP_NUMBER = 51'd1728;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_in_valid = 1'b0;
    logic [15:0] i_y = 16'h0000;
    logic        i_out_ready = 1'b0;
    logic        i_clr_ovf = 1'b0;
    logic [15:0] o_y;
    logic        o_out_valid;
    logic [2:0]  o_count;
    logic        o_full;
    logic        o_overflow;
    logic [50:0] number;

    int checks = 0;
    int errors = 0;

    sigmoid_out_fifo #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .i_in_valid(i_in_valid), .i_y(i_y),
        .i_out_ready(i_out_ready), .i_clr_ovf(i_clr_ovf), .o_y(o_y),
        .o_out_valid(o_out_valid), .o_count(o_count), .o_full(o_full),
        .o_overflow(o_overflow), .number(number)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        step();
        checks++;
        if (o_count !== 3'd0 || o_out_valid !== 1'b0 || o_y !== 16'h0000 ||
            o_full !== 1'b0 || o_overflow !== 1'b0) begin
            $display("FAIL reset_state: count=%0d valid=%b y=%h full=%b ovf=%b, need all zero",
                     o_count, o_out_valid, o_y, o_full, o_overflow);
            errors++;
        end
        checks++;
        if (number !== EXP_NUMBER) begin
            $display("FAIL number: got %0d need %0d", number, EXP_NUMBER);
            errors++;
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single;
        i_in_valid = 1'b1; i_y = 16'hFE00; i_out_ready = 1'b0;
        step();
        i_in_valid = 1'b0;
        checks++;
        if (o_out_valid !== 1'b1 || o_y !== 16'hFE00 || o_count !== 3'd1) begin
            $display("FAIL single_push: valid=%b y=%h count=%0d need 1/fe00/1", o_out_valid, o_y, o_count);
            errors++;
        end
        i_out_ready = 1'b1;
        step();
        i_out_ready = 1'b0;
        checks++;
        if (o_out_valid !== 1'b0 || o_y !== 16'h0000 || o_count !== 3'd0) begin
            $display("FAIL single_pop: valid=%b y=%h count=%0d need 0/0000/0", o_out_valid, o_y, o_count);
            errors++;
        end
        // push into empty queue with ready high: no bypass, word stays queued
        i_in_valid = 1'b1; i_y = 16'h1234; i_out_ready = 1'b1;
        step();
        i_in_valid = 1'b0; i_out_ready = 1'b0;
        checks++;
        if (o_out_valid !== 1'b1 || o_y !== 16'h1234 || o_count !== 3'd1) begin
            $display("FAIL empty_push_ready: valid=%b y=%h count=%0d need 1/1234/1", o_out_valid, o_y, o_count);
            errors++;
        end
        i_out_ready = 1'b1;
        step();
        i_out_ready = 1'b0;
    endtask

    task automatic test_fill_overflow;
        logic [15:0] w [5];
        w = '{16'hA00A, 16'hB00B, 16'hC00C, 16'hD00D, 16'hE00E};
        for (int i = 0; i < 5; i++) begin
            i_in_valid = 1'b1; i_y = w[i];
            step();
            if (i == 3) begin
                checks++;
                if (o_full !== 1'b1 || o_overflow !== 1'b0) begin
                    $display("FAIL fill_at_D: full=%b ovf=%b need 1/0", o_full, o_overflow);
                    errors++;
                end
            end
        end
        i_in_valid = 1'b0;
        checks++;
        if (o_full !== 1'b1 || o_count !== 3'd4 || o_overflow !== 1'b1) begin
            $display("FAIL fill_after_E: full=%b count=%0d ovf=%b need 1/4/1", o_full, o_count, o_overflow);
            errors++;
        end
        i_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (o_out_valid !== 1'b1 || o_y !== w[i]) begin
                $display("FAIL drain_%0d: valid=%b y=%h need 1/%h", i, o_out_valid, o_y, w[i]);
                errors++;
            end
            step();
        end
        i_out_ready = 1'b0;
        checks++;
        if (o_count !== 3'd0 || o_out_valid !== 1'b0 || o_overflow !== 1'b1) begin
            $display("FAIL drain_end: count=%0d valid=%b ovf=%b need 0/0/1", o_count, o_out_valid, o_overflow);
            errors++;
        end
        i_clr_ovf = 1'b1;
        step();
        i_clr_ovf = 1'b0;
        checks++;
        if (o_overflow !== 1'b0) begin
            $display("FAIL ovf_clear: ovf=%b need 0", o_overflow);
            errors++;
        end
    endtask

    task automatic test_pass_through;
        for (int i = 0; i < 4; i++) begin
            i_in_valid = 1'b1; i_y = 16'h5000 + 16'(i);
            step();
        end
        for (int k = 0; k < 10; k++) begin
            i_in_valid = 1'b1; i_y = 16'h5000 + 16'(k + 4); i_out_ready = 1'b1;
            checks++;
            if (o_y !== 16'h5000 + 16'(k)) begin
                $display("FAIL pass_head_%0d: y=%h need %h", k, o_y, 16'h5000 + 16'(k));
                errors++;
            end
            step();
            checks++;
            if (o_count !== 3'd4 || o_overflow !== 1'b0 || o_full !== 1'b1) begin
                $display("FAIL pass_state_%0d: count=%0d ovf=%b full=%b need 4/0/1", k, o_count, o_overflow, o_full);
                errors++;
            end
        end
        i_in_valid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (o_y !== 16'h5000 + 16'(10 + j)) begin
                $display("FAIL pass_drain_%0d: y=%h need %h", j, o_y, 16'h5000 + 16'(10 + j));
                errors++;
            end
            step();
        end
        i_out_ready = 1'b0;
        checks++;
        if (o_count !== 3'd0) begin
            $display("FAIL pass_empty: count=%0d need 0", o_count);
            errors++;
        end
    endtask

    task automatic test_wrap;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 3; i++) begin
                i_in_valid = 1'b1; i_y = 16'h7000 + 16'(r * 16 + i);
                step();
            end
            i_in_valid = 1'b0;
            checks++;
            if (o_count !== 3'd3) begin
                $display("FAIL wrap_count_r%0d: count=%0d need 3", r, o_count);
                errors++;
            end
            i_out_ready = 1'b1;
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (o_y !== 16'h7000 + 16'(r * 16 + i)) begin
                    $display("FAIL wrap_r%0d_%0d: y=%h need %h", r, i, o_y, 16'h7000 + 16'(r * 16 + i));
                    errors++;
                end
                step();
            end
            i_out_ready = 1'b0;
        end
    endtask

    task automatic test_ovf_race;
        for (int i = 0; i < 4; i++) begin
            i_in_valid = 1'b1; i_y = 16'h3000 + 16'(i);
            step();
        end
        i_y = 16'h3FFF; i_clr_ovf = 1'b1;
        step();
        i_in_valid = 1'b0;
        checks++;
        if (o_overflow !== 1'b1 || o_count !== 3'd4) begin
            $display("FAIL race_set_wins: ovf=%b count=%0d need 1/4", o_overflow, o_count);
            errors++;
        end
        step();
        i_clr_ovf = 1'b0;
        checks++;
        if (o_overflow !== 1'b0 || o_y !== 16'h3000) begin
            $display("FAIL race_clear: ovf=%b y=%h need 0/3000", o_overflow, o_y);
            errors++;
        end
    endtask

    task automatic test_reset_mid;
        // queue still holds 4 words from the race test; pop one to reach 3
        i_out_ready = 1'b1;
        step();
        i_out_ready = 1'b0;
        i_in_valid = 1'b1; i_y = 16'h3FFF;
        step();
        step();
        i_in_valid = 1'b0;
        checks++;
        if (o_overflow !== 1'b1 || o_count !== 3'd4) begin
            $display("FAIL premid_state: ovf=%b count=%0d need 1/4", o_overflow, o_count);
            errors++;
        end
        i_out_ready = 1'b1;
        step();
        i_out_ready = 1'b0;
        checks++;
        if (o_count !== 3'd3) begin
            $display("FAIL premid_count: count=%0d need 3", o_count);
            errors++;
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (o_count !== 3'd0 || o_out_valid !== 1'b0 || o_y !== 16'h0000 ||
            o_full !== 1'b0 || o_overflow !== 1'b0) begin
            $display("FAIL reset_async: count=%0d valid=%b y=%h full=%b ovf=%b need all zero",
                     o_count, o_out_valid, o_y, o_full, o_overflow);
            errors++;
        end
        #2 rst_n = 1'b1;
        step();
        i_in_valid = 1'b1; i_y = 16'hBEEF;
        step();
        i_in_valid = 1'b0;
        checks++;
        if (o_count !== 3'd1 || o_y !== 16'hBEEF || o_out_valid !== 1'b1) begin
            $display("FAIL reset_repush: count=%0d y=%h valid=%b need 1/beef/1", o_count, o_y, o_out_valid);
            errors++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_overflow();
        test_pass_through();
        test_wrap();
        test_ovf_race();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
